// File: rtl/pc_unit_if.sv
// Bus between the control/decode side and the program-counter stage.
// The master drives the control and decoded-instruction fields; the slave
// (pc_unit) returns the PC, run/halt status and perf counters.
interface pc_unit_if #(
    parameter int CNT_W = 32
);
    logic             PCWre;
    logic [1:0]       PCSrc;
    logic [31:0]      immExt;
    logic [25:0]      jAddr;
    logic             resume;
    logic [31:0]      curPC;
    logic [31:0]      nextPC;
    logic             halted;
    logic [CNT_W-1:0] instCount;
    logic [CNT_W-1:0] branchCount;

    modport master (
        output PCWre, PCSrc, immExt, jAddr, resume,
        input  curPC, nextPC, halted, instCount, branchCount
    );

    modport slave (
        input  PCWre, PCSrc, immExt, jAddr, resume,
        output curPC, nextPC, halted, instCount, branchCount
    );
endinterface

// File: rtl/pc_unit.sv
// Program-counter stage: holds the architectural PC, selects the next PC
// from the control unit's PCSrc, tracks run/halt and keeps saturating
// retired-instruction and taken-branch counters.
module pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic        CLK,
    input  logic        Reset,
    pc_unit_if.slave    bus
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    localparam logic [1:0] SRC_SEQ    = 2'b00;
    localparam logic [1:0] SRC_BRANCH = 2'b01;
    localparam logic [1:0] SRC_JUMP   = 2'b10;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] inst_cnt_q, inst_cnt_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;

    logic [31:0]        pc4;
    logic signed [31:0] imm_s;
    logic signed [31:0] br_off;
    logic [31:0]        next_pc;
    logic               halt_cond;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Next-PC selection; purely combinational and evaluated in every state.
    always_comb begin
        pc4    = pc_q + 32'd4;
        imm_s  = $signed(bus.immExt);
        br_off = imm_s <<< 2;
        unique case (bus.PCSrc)
            SRC_SEQ:    next_pc = pc4;
            SRC_BRANCH: next_pc = pc4 + br_off;
            SRC_JUMP:   next_pc = {pc4[31:28], bus.jAddr, 2'b00};
            default:    next_pc = pc_q;
        endcase
    end

    // Run/halt FSM next state, PC update and counter updates.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_cnt_d = inst_cnt_q;
        br_cnt_d   = br_cnt_q;
        halt_cond  = !bus.PCWre || (bus.PCSrc == 2'b11);
        unique case (state_q)
            RUN: begin
                // The halt instruction still retires, but a halting cycle
                // never counts as a taken branch.
                inst_cnt_d = sat_inc(inst_cnt_q);
                if (halt_cond) begin
                    state_d = HALTED;
                end else begin
                    pc_d = next_pc;
                    if (bus.PCSrc == SRC_BRANCH) begin
                        br_cnt_d = sat_inc(br_cnt_q);
                    end
                end
            end
            HALTED: begin
                // Resuming steps past the halt instruction without retiring.
                if (bus.resume) begin
                    state_d = RUN;
                    pc_d    = pc4;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // State register with synchronous reset over PC, FSM and counters.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            inst_cnt_q <= '0;
            br_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_cnt_q <= inst_cnt_d;
            br_cnt_q   <= br_cnt_d;
        end
    end

    assign bus.curPC       = pc_q;
    assign bus.nextPC      = next_pc;
    assign bus.halted      = (state_q == HALTED);
    assign bus.instCount   = inst_cnt_q;
    assign bus.branchCount = br_cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus a random run,
// all compared against a behavioural model of the PC stage.
module tb_pc_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          CNT_W    = 8;

    logic CLK;
    logic Reset;

    pc_unit_if #(.CNT_W(CNT_W)) bus ();

    pc_unit #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0]      m_pc;
    logic             m_halted;
    logic [CNT_W-1:0] m_inst;
    logic [CNT_W-1:0] m_br;

    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [1:0] src,
                                             input logic [31:0] imm, input logic [25:0] ja);
        logic [31:0] seq;
        seq = pc + 32'd4;
        case (src)
            2'd0:    return seq;
            2'd1:    return seq + imm * 32'd4;
            2'd2:    return (seq & 32'hF000_0000) | ({6'd0, ja} * 32'd4);
            default: return pc;
        endcase
    endfunction

    task automatic drive(input logic r, input logic we, input logic [1:0] src,
                         input logic [31:0] imm, input logic [25:0] ja, input logic res);
        Reset      = r;
        bus.PCWre  = we;
        bus.PCSrc  = src;
        bus.immExt = imm;
        bus.jAddr  = ja;
        bus.resume = res;
    endtask

    // Advance one clock and apply the architectural rules to the model.
    task automatic clk_edge();
        logic [CNT_W-1:0] all1;
        all1 = '1;
        @(posedge CLK);
        if (Reset) begin
            m_pc = RESET_PC; m_halted = 1'b0; m_inst = '0; m_br = '0;
        end else if (m_halted) begin
            if (bus.resume) begin
                m_pc = m_pc + 32'd4;
                m_halted = 1'b0;
            end
        end else begin
            if (m_inst != all1) m_inst = m_inst + 1'b1;
            if (!bus.PCWre || bus.PCSrc == 2'd3) begin
                m_halted = 1'b1;
            end else begin
                m_pc = ref_next(m_pc, bus.PCSrc, bus.immExt, bus.jAddr);
                if (bus.PCSrc == 2'd1 && m_br != all1) m_br = m_br + 1'b1;
            end
        end
        #1;
    endtask

    task automatic step(input logic we, input logic [1:0] src,
                        input logic [31:0] imm, input logic [25:0] ja, input logic res);
        drive(1'b0, we, src, imm, ja, res);
        clk_edge();
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b1, 2'd0, 32'd0, 26'd0, 1'b0);
        clk_edge();
        Reset = 1'b0;
    endtask

    // Taken branch landing exactly on target (used to position the PC).
    task automatic goto_pc(input logic [31:0] target);
        logic [31:0] diff;
        diff = target - m_pc - 32'd4;
        step(1'b1, 2'd1, $signed(diff) >>> 2, 26'd0, 1'b0);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 2'd3, $urandom, 26'($urandom), 1'b1);
        clk_edge();
        checks++; if (bus.curPC !== RESET_PC) begin errors++; $display("FAIL reset_pc got %h want %h", bus.curPC, RESET_PC); end
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", bus.halted); end
        checks++; if (bus.instCount !== '0 || bus.branchCount !== '0) begin errors++; $display("FAIL reset_counts got %0d/%0d want 0/0", bus.instCount, bus.branchCount); end
        drive(1'b0, 1'b1, 2'd0, 32'd0, 26'd0, 1'b0);
        #1;
        checks++; if (bus.nextPC !== 32'h4) begin errors++; $display("FAIL reset_nextpc got %h want 00000004", bus.nextPC); end
    endtask

    task automatic test_sequential();
        logic [31:0] want;
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, 2'd0, $urandom, 26'($urandom), 1'b0);
            want = 32'(i * 4);
            checks++; if (bus.curPC !== want) begin errors++; $display("FAIL seq_pc%0d got %h want %h", i, bus.curPC, want); end
        end
        checks++; if (bus.instCount !== 8'd3 || bus.branchCount !== 8'd0 || bus.halted !== 1'b0) begin
            errors++; $display("FAIL seq_counts got inst=%0d br=%0d halted=%b want 3/0/0", bus.instCount, bus.branchCount, bus.halted);
        end
    endtask

    task automatic test_branch();
        logic [CNT_W-1:0] br0;
        goto_pc(32'h10);
        br0 = bus.branchCount;
        step(1'b1, 2'd1, 32'h0000_0003, 26'd0, 1'b0);
        checks++; if (bus.curPC !== 32'h20) begin errors++; $display("FAIL branch_fwd got %h want 00000020", bus.curPC); end
        checks++; if (bus.branchCount !== br0 + 1'b1) begin errors++; $display("FAIL branch_count got %0d want %0d", bus.branchCount, br0 + 1'b1); end
        step(1'b1, 2'd1, 32'hFFFF_FFFE, 26'd0, 1'b0);
        checks++; if (bus.curPC !== 32'h1C) begin errors++; $display("FAIL branch_back got %h want 0000001c", bus.curPC); end
    endtask

    task automatic test_jump();
        logic [CNT_W-1:0] br0;
        goto_pc(32'hA000_0040);
        br0 = bus.branchCount;
        step(1'b1, 2'd2, $urandom, 26'h000_0010, 1'b0);
        checks++; if (bus.curPC !== 32'hA000_0040) begin errors++; $display("FAIL jump_hi got %h want a0000040", bus.curPC); end
        checks++; if (bus.branchCount !== br0) begin errors++; $display("FAIL jump_br got %0d want %0d", bus.branchCount, br0); end
        goto_pc(32'h10);
        br0 = bus.branchCount;
        step(1'b1, 2'd2, $urandom, 26'h000_0010, 1'b0);
        checks++; if (bus.curPC !== 32'h40) begin errors++; $display("FAIL jump_lo got %h want 00000040", bus.curPC); end
        checks++; if (bus.branchCount !== br0) begin errors++; $display("FAIL jump_br2 got %0d want %0d", bus.branchCount, br0); end
    endtask

    task automatic test_halt();
        logic [CNT_W-1:0] inst0, br0;
        goto_pc(32'h18);
        inst0 = bus.instCount;
        br0   = bus.branchCount;
        step(1'b0, 2'd3, $urandom, 26'($urandom), 1'b0);
        checks++; if (bus.curPC !== 32'h18 || bus.halted !== 1'b1) begin errors++; $display("FAIL halt_enter got pc=%h halted=%b want 00000018/1", bus.curPC, bus.halted); end
        checks++; if (bus.instCount !== inst0 + 1'b1 || bus.branchCount !== br0) begin
            errors++; $display("FAIL halt_counts got %0d/%0d want %0d/%0d", bus.instCount, bus.branchCount, inst0 + 1'b1, br0);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'($urandom), 2'($urandom), $urandom, 26'($urandom), 1'b0);
            checks++; if (bus.curPC !== 32'h18 || bus.halted !== 1'b1 || bus.instCount !== inst0 + 1'b1 || bus.branchCount !== br0) begin
                errors++; $display("FAIL halt_hold%0d got pc=%h h=%b inst=%0d br=%0d", i, bus.curPC, bus.halted, bus.instCount, bus.branchCount);
            end
        end
    endtask

    task automatic test_resume();
        logic [CNT_W-1:0] inst0, br0;
        inst0 = bus.instCount;
        br0   = bus.branchCount;
        step(1'b1, 2'd3, $urandom, 26'($urandom), 1'b1);
        checks++; if (bus.curPC !== 32'h1C || bus.halted !== 1'b0) begin errors++; $display("FAIL resume got pc=%h halted=%b want 0000001c/0", bus.curPC, bus.halted); end
        checks++; if (bus.instCount !== inst0 || bus.branchCount !== br0) begin errors++; $display("FAIL resume_counts got %0d/%0d want %0d/%0d", bus.instCount, bus.branchCount, inst0, br0); end
        step(1'b1, 2'd0, 32'd0, 26'd0, 1'b1);
        checks++; if (bus.curPC !== 32'h20 || bus.instCount !== inst0 + 1'b1) begin errors++; $display("FAIL resume_in_run got pc=%h inst=%0d want 00000020/%0d", bus.curPC, bus.instCount, inst0 + 1'b1); end
        // PCWre=0 with PCSrc=01 halts without counting a branch
        br0 = bus.branchCount;
        step(1'b0, 2'd1, 32'd5, 26'd0, 1'b0);
        checks++; if (bus.halted !== 1'b1 || bus.curPC !== 32'h20 || bus.branchCount !== br0) begin
            errors++; $display("FAIL halt_branch got h=%b pc=%h br=%0d want 1/00000020/%0d", bus.halted, bus.curPC, bus.branchCount, br0);
        end
    endtask

    task automatic test_reset_halted();
        drive(1'b1, 1'b1, 2'd1, $urandom, 26'($urandom), 1'b1);
        clk_edge();
        checks++; if (bus.curPC !== RESET_PC || bus.halted !== 1'b0 || bus.instCount !== '0 || bus.branchCount !== '0) begin
            errors++; $display("FAIL reset_halted got pc=%h h=%b inst=%0d br=%0d want 0/0/0/0", bus.curPC, bus.halted, bus.instCount, bus.branchCount);
        end
        Reset = 1'b0;
    endtask

    task automatic test_wrap();
        goto_pc(32'hFFFF_FFFC);
        checks++; if (bus.curPC !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pos got %h want fffffffc", bus.curPC); end
        step(1'b1, 2'd0, 32'd0, 26'd0, 1'b0);
        checks++; if (bus.curPC !== 32'h0) begin errors++; $display("FAIL wrap got %h want 00000000", bus.curPC); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 300; i++) step(1'b1, 2'd1, 32'd0, 26'd0, 1'b0);
        checks++; if (bus.instCount !== 8'hFF || bus.branchCount !== 8'hFF) begin
            errors++; $display("FAIL saturate got %0d/%0d want 255/255", bus.instCount, bus.branchCount);
        end
        checks++; if (bus.curPC !== m_pc) begin errors++; $display("FAIL saturate_pc got %h want %h", bus.curPC, m_pc); end
    endtask

    task automatic test_random();
        logic [31:0] exp_next;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0), 2'($urandom),
                  $urandom, 26'($urandom), ($urandom_range(0, 3) == 0));
            #1;
            exp_next = ref_next(m_pc, bus.PCSrc, bus.immExt, bus.jAddr);
            checks++; if (bus.nextPC !== exp_next) begin errors++; $display("FAIL rnd_next%0d got %h want %h", i, bus.nextPC, exp_next); end
            clk_edge();
            checks++; if (bus.curPC !== m_pc || bus.halted !== m_halted || bus.instCount !== m_inst || bus.branchCount !== m_br) begin
                errors++; $display("FAIL rnd_state%0d got pc=%h h=%b inst=%0d br=%0d want pc=%h h=%b inst=%0d br=%0d",
                                   i, bus.curPC, bus.halted, bus.instCount, bus.branchCount, m_pc, m_halted, m_inst, m_br);
            end
        end
        Reset = 1'b0;
    endtask

    initial begin
        m_pc = RESET_PC; m_halted = 1'b0; m_inst = '0; m_br = '0;
        drive(1'b1, 1'b1, 2'd0, 32'd0, 26'd0, 1'b0);
        @(negedge CLK);
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_halt();
        test_resume();
        test_reset_halted();
        test_wrap();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Program-counter stage directly downstream of the control unit.
- Consumes PCWre and PCSrc from the control unit, plus the sign-extended immediate and jump target field from the decoded instruction.
- Holds the architectural PC, computes the next PC, and manages run/halt state.
- Keeps retired-instruction and taken-branch counters for the debug/perf readout.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned (bits [1:0] = 0).
- CNT_W, 32, width of instCount and branchCount.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- PCWre  input  1  from control unit; 0 = halt instruction, PC must not advance.
- PCSrc  input  2  from control unit:
  - 00 = PC+4
  - 01 = branch taken
  - 10 = jump
  - 11 = halt/hold
- immExt  input  32  sign/zero-extended 16-bit immediate of current instruction.
- jAddr  input  26  instruction bits [25:0] (jump target field).
- resume  input  1  restart request, honoured only in HALTED.
- curPC  output  32  current PC, feeds instruction memory address.
- nextPC  output  32  combinational next-PC value (for debug display).
- halted  output  1  1 while FSM is in HALTED.
- instCount  output  CNT_W  retired-instruction count.
- branchCount  output  CNT_W  taken-branch count.

Behaviour:
- Reset (Reset=1 at a rising edge) sets:
  - curPC = RESET_PC
  - state = RUN
  - halted = 0
  - instCount = 0
  - branchCount = 0
- Reset overrides resume and all other inputs, including when asserted while HALTED.
- pc4 = curPC + 4, modulo 2^32 (wraps from 32'hFFFF_FFFC to 0).
- nextPC is purely combinational from curPC, PCSrc, immExt and jAddr (no latency):
  - PCSrc=00 -> pc4
  - PCSrc=01 -> pc4 + (immExt << 2), modulo 2^32; a negative immExt gives a backward branch.
  - PCSrc=10 -> {pc4[31:28], jAddr, 2'b00}
  - PCSrc=11 -> curPC
- nextPC is computed in every state; in HALTED it is informational only.
- FSM states: RUN, HALTED.
- RUN, halt condition (PCWre=0 or PCSrc=11):
  - curPC holds.
  - state moves to HALTED; halted=1 from the next cycle.
  - instCount increments (the halt instruction itself retires).
- RUN, otherwise:
  - curPC <= nextPC.
  - instCount increments.
  - branchCount increments only when PCSrc=01.
- A cycle with PCWre=0 and PCSrc=01 counts as halt, not a branch: branchCount is not incremented.
- HALTED:
  - curPC, instCount and branchCount hold.
  - PCWre, PCSrc, immExt and jAddr are ignored.
- HALTED with resume=1:
  - state returns to RUN; curPC <= curPC + 4, skipping the halt instruction.
  - halted=0 from the next cycle; counters are not incremented that cycle.
- resume asserted while in RUN has no effect.
- Counters saturate at all-ones; they do not wrap.
- Single-cycle design: every RUN cycle retires exactly one instruction. There is no stall input.

Test Plan:
- Reset, then 3 cycles with PCSrc=00, PCWre=1 -> curPC 0, 4, 8, 12; instCount=3; branchCount=0; halted=0.
- At curPC=32'h10, PCSrc=01, immExt=32'h0000_0003 -> next curPC=32'h20, branchCount+1. Then immExt=32'hFFFF_FFFE at curPC=32'h20 -> curPC=32'h1C.
- At curPC=32'hA000_0040, PCSrc=10, jAddr=26'h000_0010 -> curPC=32'hA000_0040; at curPC=32'h10, same jAddr -> curPC=32'h40. branchCount unchanged in both cases.
- At curPC=32'h18, PCWre=0, PCSrc=11 -> curPC holds at 32'h18, halted=1, instCount+1. Random PCSrc/immExt for 5 cycles -> no change to curPC or counters.
- While halted at 32'h18, pulse resume for 1 cycle -> halted=0 and curPC=32'h1C on the next edge; counters unchanged by the resume cycle.
- Assert Reset while HALTED together with resume=1 -> curPC=RESET_PC, halted=0, both counters 0.
